// File: rtl/riscv_rf_pkg.sv
// Shared register-file definitions: default sizes, sequencer state type and
// the address-width helper used by every file of the register file.
package riscv_rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  // INIT clears the array one entry per cycle; RUN is normal operation.
  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  // Address width for a file of n registers.
  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file port bundle. The master drives writes, reads and issue events.
// The slave (the register file) returns read data, busy flags and ready.
// Handshake: none. Every we/iss_v pulse is consumed on the edge where it is
// high. ready marks when those pulses start taking effect. The issue stage
// must stall on rbusy itself.
interface regfile_mp_if
  import riscv_rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = rf_aw(NREGS);

  logic                 ready;
  logic [NWR-1:0]       we;
  logic [NWR*AW-1:0]    waddr;
  logic [NWR*XLEN-1:0]  wdata;
  logic [NRD-1:0]       re;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD-1:0]       rbusy;
  logic                 iss_v;
  logic [AW-1:0]        iss_rd;

  modport master (
    input  ready, rdata, rbusy,
    output we, waddr, wdata, re, raddr, iss_v, iss_rd
  );

  modport slave (
    output ready, rdata, rbusy,
    input  we, waddr, wdata, re, raddr, iss_v, iss_rd
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register. Issue sets the bit and
// writeback clears it. A same-cycle write to a looked-up register hides its
// busy bit, so the reader wakes together with the data bypass.
module regfile_scoreboard #(
  parameter int NREGS    = 32,
  parameter int NWR      = 2,
  parameter int NRD      = 2,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_iss_v,
  input  logic [AW-1:0]     i_iss_rd,
  input  logic [NWR-1:0]    i_we,
  input  logic [NWR*AW-1:0] i_waddr,
  input  logic [NRD-1:0]    i_re,
  input  logic [NRD*AW-1:0] i_raddr,
  output logic [NRD-1:0]    o_rbusy
);

  logic [NREGS-1:0] r_sb;
  logic [NREGS-1:0] w_sb_next;
  logic [AW-1:0]    w_look_addr;
  logic             w_wr_hit;

  // Next scoreboard: clears first, then the issue set overrides (younger producer).
  always_comb begin
    w_sb_next = r_sb;
    for (int i = 0; i < NWR; i++) begin
      if (i_we[i]) w_sb_next[i_waddr[i*AW +: AW]] = 1'b0;
    end
    if (i_iss_v && !(ZERO_REG != 0 && i_iss_rd == '0)) w_sb_next[i_iss_rd] = 1'b1;
  end

  // Scoreboard state: cleared by reset, frozen outside RUN.
  always_ff @(posedge clk) begin
    if (!rst) r_sb <= '0;
    else if (i_en) r_sb <= w_sb_next;
  end

  // Per-port busy lookup with same-cycle writeback wakeup.
  always_comb begin
    o_rbusy     = '0;
    w_look_addr = '0;
    w_wr_hit    = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      w_look_addr = i_raddr[j*AW +: AW];
      w_wr_hit    = 1'b0;
      for (int i = 0; i < NWR; i++) begin
        if (i_we[i] && i_waddr[i*AW +: AW] == w_look_addr) w_wr_hit = 1'b1;
      end
      o_rbusy[j] = i_en & i_re[j] & r_sb[w_look_addr] & ~w_wr_hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file. It has a post-reset clear sequencer, a
// hardwired zero register, write-to-read bypass and a pending-write scoreboard.
module regfile_mp
  import riscv_rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic       clk,
  input  logic       rst,
  regfile_mp_if.slave bus,
  output rf_state_t  o_dbg_state
);

  localparam int AW = rf_aw(NREGS);

  rf_state_t         r_state;
  logic [AW-1:0]     r_idx;
  logic [XLEN-1:0]   r_regs [NREGS];
  logic              w_run;
  logic [AW-1:0]     w_rd_addr;
  logic [XLEN-1:0]   w_rd_val;
  logic [NRD*XLEN-1:0] w_rdata;

  // Everything architectural is gated until the clear sequence has finished.
  assign w_run       = rst && (r_state == RF_RUN);
  assign bus.ready   = w_run;
  assign o_dbg_state = r_state;

  // Clear sequencer: walk idx over every register, then enter RUN.
  // idx wraps on the same edge that enters RUN, so no overflow state is needed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RF_INIT;
      r_idx   <= '0;
    end else if (r_state == RF_INIT) begin
      r_idx <= r_idx + 1'b1;
      if (r_idx == AW'(NREGS - 1)) r_state <= RF_RUN;
    end
  end

  // Storage: zero fill in INIT. In RUN, ports are applied in ascending order,
  // so the highest index wins.
  always_ff @(posedge clk) begin
    if (rst && r_state == RF_INIT) begin
      r_regs[r_idx] <= '0;
    end else if (w_run) begin
      for (int i = 0; i < NWR; i++) begin
        if (bus.we[i] && !(ZERO_REG != 0 && bus.waddr[i*AW +: AW] == '0))
          r_regs[bus.waddr[i*AW +: AW]] <= bus.wdata[i*XLEN +: XLEN];
      end
    end
  end

  // Read ports: the array value, overridden by the highest-index same-cycle writer.
  always_comb begin
    w_rdata   = '0;
    w_rd_addr = '0;
    w_rd_val  = '0;
    for (int j = 0; j < NRD; j++) begin
      w_rd_addr = bus.raddr[j*AW +: AW];
      w_rd_val  = r_regs[w_rd_addr];
      for (int i = 0; i < NWR; i++) begin
        if (bus.we[i] && bus.waddr[i*AW +: AW] == w_rd_addr)
          w_rd_val = bus.wdata[i*XLEN +: XLEN];
      end
      if (w_run && bus.re[j] && !(ZERO_REG != 0 && w_rd_addr == '0))
        w_rdata[j*XLEN +: XLEN] = w_rd_val;
    end
  end

  assign bus.rdata = w_rdata;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .NRD      (NRD),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_run),
    .i_iss_v  (bus.iss_v),
    .i_iss_rd (bus.iss_rd),
    .i_we     (bus.we),
    .i_waddr  (bus.waddr),
    .i_re     (bus.re),
    .i_raddr  (bus.raddr),
    .o_rbusy  (bus.rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters (32 x 32, 2R/2W, x0 hardwired).
module tb_regfile_mp;
  import riscv_rf_pkg::*;

  logic      clk;
  logic      rst;
  rf_state_t dbg_state;
  int        n_tests;
  int        n_fail;
  int        cnt;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rdat(input int j);
    return bus.rdata[j*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.we[p]          = en;
    bus.waddr[p*5 +: 5] = a;
    bus.wdata[p*32 +: 32] = d;
  endtask

  task automatic drive_rd(input int p, input logic en, input logic [4:0] a);
    bus.re[p]           = en;
    bus.raddr[p*5 +: 5] = a;
  endtask

  task automatic idle();
    bus.we = '0; bus.waddr = '0; bus.wdata = '0;
    bus.re = '0; bus.raddr = '0;
    bus.iss_v = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_rd(0, 1'b1, 5'd1);
    repeat (3) tick();
    n_tests++;
    if (bus.ready !== 1'b0 || rdat(0) !== 32'h0 || bus.rbusy !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rdata=%h rbusy=%b, want 0/0/0", bus.ready, rdat(0), bus.rbusy);
    end
    rst = 1'b1;
    cnt = 0;
    while (!bus.ready && cnt < 100) begin
      tick();
      cnt++;
    end
    n_tests++;
    if (cnt !== 32) begin
      n_fail++;
      $display("FAIL reset_clear_latency: ready after %0d cycles, want 32", cnt);
    end
    n_tests++;
    if (dbg_state !== RF_RUN) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d want RF_RUN", dbg_state);
    end
    for (int r = 0; r < 32; r++) begin
      drive_rd(0, 1'b1, 5'(r));
      #1;
      n_tests++;
      if (rdat(0) !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg_zero x%0d: got %h want 00000000", r, rdat(0));
      end
    end
    idle();
  endtask

  task automatic test_bypass_priority();
    tick();
    drive_wr(0, 1'b1, 5'd5, 32'h11111111);
    drive_wr(1, 1'b1, 5'd5, 32'h22222222);
    drive_rd(0, 1'b1, 5'd5);
    #1;
    n_tests++;
    if (rdat(0) !== 32'h22222222) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got %h want 22222222", rdat(0));
    end
    tick();
    drive_wr(0, 1'b0, 5'd0, 32'h0);
    drive_wr(1, 1'b0, 5'd0, 32'h0);
    #1;
    n_tests++;
    if (rdat(0) !== 32'h22222222) begin
      n_fail++;
      $display("FAIL bypass_array_next: got %h want 22222222", rdat(0));
    end
    drive_rd(0, 1'b0, 5'd5);
    #1;
    n_tests++;
    if (rdat(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL read_disabled: got %h want 00000000", rdat(0));
    end
    idle();
  endtask

  task automatic test_two_ports();
    tick();
    drive_wr(0, 1'b1, 5'd10, 32'hA0A0_0010);
    drive_wr(1, 1'b1, 5'd11, 32'hB0B0_0011);
    tick();
    idle();
    drive_rd(0, 1'b1, 5'd11);
    drive_rd(1, 1'b1, 5'd10);
    #1;
    n_tests++;
    if (rdat(0) !== 32'hB0B0_0011 || rdat(1) !== 32'hA0A0_0010) begin
      n_fail++;
      $display("FAIL two_ports: got %h/%h want b0b00011/a0a00010", rdat(0), rdat(1));
    end
    idle();
  endtask

  task automatic test_zero_reg();
    tick();
    drive_wr(0, 1'b1, 5'd0, 32'hDEADBEEF);
    drive_wr(1, 1'b1, 5'd0, 32'hDEADBEEF);
    drive_rd(0, 1'b1, 5'd0);
    #1;
    n_tests++;
    if (rdat(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_same_cycle: got %h want 00000000", rdat(0));
    end
    tick();
    drive_wr(0, 1'b0, 5'd0, 32'h0);
    drive_wr(1, 1'b0, 5'd0, 32'h0);
    bus.iss_v = 1'b1; bus.iss_rd = 5'd0;
    #1;
    n_tests++;
    if (rdat(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_next_cycle: got %h want 00000000", rdat(0));
    end
    tick();
    bus.iss_v = 1'b0;
    #1;
    n_tests++;
    if (bus.rbusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_not_busy: rbusy=%b want 0", bus.rbusy[0]);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    tick();
    bus.iss_v = 1'b1; bus.iss_rd = 5'd7;
    drive_rd(1, 1'b1, 5'd7);
    #1;
    n_tests++;
    if (bus.rbusy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_issue_not_visible: rbusy=%b want 0", bus.rbusy[1]);
    end
    tick();
    bus.iss_v = 1'b0;
    #1;
    n_tests++;
    if (bus.rbusy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_issue_visible: rbusy=%b want 1", bus.rbusy[1]);
    end
    drive_wr(1, 1'b1, 5'd7, 32'hA5A5A5A5);
    #1;
    n_tests++;
    if (bus.rbusy[1] !== 1'b0 || rdat(1) !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL sb_wakeup: rbusy=%b rdata=%h want 0/a5a5a5a5", bus.rbusy[1], rdat(1));
    end
    tick();
    drive_wr(1, 1'b0, 5'd0, 32'h0);
    #1;
    n_tests++;
    if (bus.rbusy[1] !== 1'b0 || rdat(1) !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL sb_cleared: rbusy=%b rdata=%h want 0/a5a5a5a5", bus.rbusy[1], rdat(1));
    end
    bus.iss_v = 1'b1; bus.iss_rd = 5'd7;
    drive_wr(1, 1'b1, 5'd7, 32'h5A5A5A5A);
    tick();
    bus.iss_v = 1'b0;
    drive_wr(1, 1'b0, 5'd0, 32'h0);
    #1;
    n_tests++;
    if (bus.rbusy[1] !== 1'b1 || rdat(1) !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL sb_set_wins: rbusy=%b rdata=%h want 1/5a5a5a5a", bus.rbusy[1], rdat(1));
    end
    drive_rd(1, 1'b0, 5'd7);
    #1;
    n_tests++;
    if (bus.rbusy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_re_gated: rbusy=%b want 0", bus.rbusy[1]);
    end
    drive_wr(0, 1'b1, 5'd7, 32'h0000_0007);
    tick();
    idle();
  endtask

  task automatic test_mid_reset();
    tick();
    drive_wr(0, 1'b1, 5'd3, 32'hCAFEF00D);
    tick();
    drive_wr(0, 1'b0, 5'd0, 32'h0);
    bus.iss_v = 1'b1; bus.iss_rd = 5'd3;
    tick();
    bus.iss_v = 1'b0;
    drive_rd(0, 1'b1, 5'd3);
    drive_rd(1, 1'b1, 5'd9);
    #1;
    n_tests++;
    if (bus.rbusy[0] !== 1'b1 || rdat(0) !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL midrst_setup: rbusy=%b rdata=%h want 1/cafef00d", bus.rbusy[0], rdat(0));
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cnt = 0;
    while (!bus.ready && cnt < 100) begin
      if (cnt == 10) drive_wr(0, 1'b1, 5'd9, 32'h12345678);
      else drive_wr(0, 1'b0, 5'd0, 32'h0);
      #1;
      n_tests++;
      if (bus.rbusy !== 2'b00 || rdat(0) !== 32'h0 || rdat(1) !== 32'h0) begin
        n_fail++;
        $display("FAIL midrst_init_outputs cycle %0d: rbusy=%b rdata0=%h rdata1=%h want 0", cnt, bus.rbusy, rdat(0), rdat(1));
      end
      tick();
      cnt++;
    end
    drive_wr(0, 1'b0, 5'd0, 32'h0);
    n_tests++;
    if (cnt !== 32) begin
      n_fail++;
      $display("FAIL midrst_clear_latency: ready after %0d cycles, want 32", cnt);
    end
    #1;
    n_tests++;
    if (rdat(0) !== 32'h0 || bus.rbusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_x3_cleared: rdata=%h rbusy=%b want 0/0", rdat(0), bus.rbusy[0]);
    end
    n_tests++;
    if (rdat(1) !== 32'h0) begin
      n_fail++;
      $display("FAIL init_write_ignored x9: got %h want 00000000", rdat(1));
    end
    idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    idle();
    test_reset();
    test_bypass_priority();
    test_two_ports();
    test_zero_reg();
    test_scoreboard();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
